count_monitor: RTL and testbench

Parametrised, synthesizable checker for an up/down/loadable counter with a terminal-count flag. It runs a cycle-accurate shadow model beside the counter under test, compares count and terminal count every cycle, and keeps saturating check and error tallies. It is bound next to the counter in simulation and emulation, and it generalises the fixed 4-bit up-count pass/fail check.

---
 rtl/count_monitor_pkg.sv | 24 ++
 rtl/count_monitor_model.sv | 63 ++++++
 rtl/count_monitor.sv | 143 ++++++++++++++
 tb/tb_count_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor_pkg
// Description : Shared types and helpers for the counter monitor: the FSM
//               state encoding and a saturating increment for the tallies.
// Revision    : 1.0 - initial release
// ============================================================================
package count_monitor_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      CHECK = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Increment v, but never past the all-ones value of a w-bit field.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] lim;
      lim = (32'd1 << w) - 32'd1;
      return (v >= lim) ? v : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/count_monitor_model.sv
`default_nettype none
// ============================================================================
// Module      : count_model
// Description : Shadow counter. Tracks the value the counter under test must
//               show after each edge: load > enable > hold, modulo MAX+1.
//               When seed_i is set the update starts from the observed count
//               instead of the internal value (initial sync and resync).
// Revision    : 1.0 - initial release
// ============================================================================
module count_model
   import count_monitor_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter int unsigned MAX   = 2**WIDTH - 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             seed_i,
   input  logic [WIDTH-1:0] seed_val_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] exp_o
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] exp_d;
   logic [WIDTH-1:0] base;

   // Next expected value: pick the starting point, then apply the controls.
   always_comb begin
      base  = seed_i ? seed_val_i : exp_q;
      exp_d = base;
      if (load_i) begin
         exp_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            exp_d = (base == MAX_V) ? '0 : base + 1'b1;
         end else begin
            exp_d = (base == '0) ? MAX_V : base - 1'b1;
         end
      end
   end

   // Expected-value register; clr returns it to the reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q <= '0;
      end else if (clr_i) begin
         exp_q <= '0;
      end else begin
         exp_q <= exp_d;
      end
   end

   assign exp_o = exp_q;

endmodule
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Cycle-accurate checker for an up/down/loadable counter with a
//               terminal-count flag. Compares count and t against a shadow
//               model, raises one-cycle error pulses, a sticky fail flag and
//               saturating error/check tallies.
// Revision    : 1.0 - initial release
// ============================================================================
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int          WIDTH       = 4,
   parameter int unsigned MAX         = 2**WIDTH - 1,
   parameter int          ERR_W       = 8,
   parameter bit          STOP_ON_ERR = 1'b0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] count,
   input  logic             t,
   output logic             cnt_err,
   output logic             t_err,
   output logic             fail,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] chk_cnt,
   output logic [1:0]       state
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   state_t           state_q, state_d;
   logic             cnt_err_q, cnt_err_d;
   logic             t_err_q, t_err_d;
   logic             fail_q, fail_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_W-1:0] chk_cnt_q, chk_cnt_d;

   logic [WIDTH-1:0] exp_val;
   logic             cnt_mis;
   logic             t_mis;
   logic             t_exp;
   logic             seed;

   // Raw comparisons against the model and the observed count.
   always_comb begin
      cnt_mis = (count != exp_val) || (count > MAX_V);
      t_exp   = up ? (count == MAX_V) : (count == '0);
      t_mis   = (t != t_exp);
      // Outside CHECK, and after a count error, the model follows the
      // observed counter so a single fault does not cascade.
      seed    = (state_q != CHECK) || cnt_mis;
   end

   count_model #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_model (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clr),
      .seed_i     (seed),
      .seed_val_i (count),
      .load_i     (load),
      .load_val_i (load_val),
      .en_i       (en),
      .up_i       (up),
      .exp_o      (exp_val)
   );

   // Next state, error pulses and tallies; clr overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_err_d = 1'b0;
      t_err_d   = 1'b0;
      fail_d    = fail_q;
      err_cnt_d = err_cnt_q;
      chk_cnt_d = chk_cnt_q;
      if (clr) begin
         state_d   = SYNC;
         fail_d    = 1'b0;
         err_cnt_d = '0;
         chk_cnt_d = '0;
      end else begin
         case (state_q)
            SYNC: begin
               state_d = CHECK;
            end
            CHECK: begin
               cnt_err_d = cnt_mis;
               t_err_d   = t_mis;
               chk_cnt_d = ERR_W'(sat_inc(32'(chk_cnt_q), ERR_W));
               if (cnt_mis || t_mis) begin
                  fail_d    = 1'b1;
                  err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_W));
                  if (STOP_ON_ERR) begin
                     state_d = HALT;
                  end
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = SYNC;
            end
         endcase
      end
   end

   // State and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SYNC;
         cnt_err_q <= 1'b0;
         t_err_q   <= 1'b0;
         fail_q    <= 1'b0;
         err_cnt_q <= '0;
         chk_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_err_q <= cnt_err_d;
         t_err_q   <= t_err_d;
         fail_q    <= fail_d;
         err_cnt_q <= err_cnt_d;
         chk_cnt_q <= chk_cnt_d;
      end
   end

   assign cnt_err = cnt_err_q;
   assign t_err   = t_err_q;
   assign fail    = fail_q;
   assign err_cnt = err_cnt_q;
   assign chk_cnt = chk_cnt_q;
   assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_count_monitor
// Description : Bench for count_monitor. Three monitors watch three counters
//               driven from the bench:
//                 u0: WIDTH=4 MAX=15 ERR_W=8 STOP_ON_ERR=0
//                 u1: WIDTH=4 MAX=9  ERR_W=3 STOP_ON_ERR=0
//                 u2: WIDTH=4 MAX=15 ERR_W=3 STOP_ON_ERR=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       en_s  [N];
   logic       up_s  [N];
   logic       ld_s  [N];
   logic       t_s   [N];
   logic [3:0] lv_s  [N];
   logic [3:0] cnt_s [N];
   logic       ce_o  [N];
   logic       te_o  [N];
   logic       fl_o  [N];
   logic [1:0] st_o  [N];
   logic [7:0] ec0, cc0;
   logic [2:0] ec1, cc1, ec2, cc2;

   int total = 0;
   int bad   = 0;

   // Reference model state (state: 0=SYNC 1=CHECK 2=HALT)
   int m_st [N];
   int m_exp[N];
   int m_ec [N];
   int m_cc [N];
   bit m_fail[N];
   bit m_ce [N];
   bit m_te [N];
   int mb;
   bit mce, mte;

   // Ideal counter values driven by the bench
   int ctr  [N];
   bit tflip[N];

   always #5 clk = ~clk;

   count_monitor #(.WIDTH(4), .MAX(15), .ERR_W(8), .STOP_ON_ERR(1'b0)) u0 (
      .clk(clk), .reset(rst), .clr(clr), .en(en_s[0]), .up(up_s[0]), .load(ld_s[0]),
      .load_val(lv_s[0]), .count(cnt_s[0]), .t(t_s[0]), .cnt_err(ce_o[0]), .t_err(te_o[0]),
      .fail(fl_o[0]), .err_cnt(ec0), .chk_cnt(cc0), .state(st_o[0]));

   count_monitor #(.WIDTH(4), .MAX(9), .ERR_W(3), .STOP_ON_ERR(1'b0)) u1 (
      .clk(clk), .reset(rst), .clr(clr), .en(en_s[1]), .up(up_s[1]), .load(ld_s[1]),
      .load_val(lv_s[1]), .count(cnt_s[1]), .t(t_s[1]), .cnt_err(ce_o[1]), .t_err(te_o[1]),
      .fail(fl_o[1]), .err_cnt(ec1), .chk_cnt(cc1), .state(st_o[1]));

   count_monitor #(.WIDTH(4), .MAX(15), .ERR_W(3), .STOP_ON_ERR(1'b1)) u2 (
      .clk(clk), .reset(rst), .clr(clr), .en(en_s[2]), .up(up_s[2]), .load(ld_s[2]),
      .load_val(lv_s[2]), .count(cnt_s[2]), .t(t_s[2]), .cnt_err(ce_o[2]), .t_err(te_o[2]),
      .fail(fl_o[2]), .err_cnt(ec2), .chk_cnt(cc2), .state(st_o[2]));

   function automatic int maxv(input int i);
      return (i == 1) ? 9 : 15;
   endfunction

   function automatic int errmax(input int i);
      return (i == 0) ? 255 : 7;
   endfunction

   function automatic bit stop(input int i);
      return (i == 2);
   endfunction

   function automatic int ec_of(input int i);
      case (i)
         0:       return int'(ec0);
         1:       return int'(ec1);
         default: return int'(ec2);
      endcase
   endfunction

   function automatic int cc_of(input int i);
      case (i)
         0:       return int'(cc0);
         1:       return int'(cc1);
         default: return int'(cc2);
      endcase
   endfunction

   // Counter behaviour: load wins, then enable, modulo max+1 (4-bit register).
   function automatic int cnext(input int i, input int c, input logic en,
                                input logic up, input logic ld, input logic [3:0] lv);
      if (ld) return int'(lv);
      if (en) begin
         if (up) return (c == maxv(i)) ? 0 : (c + 1) % 16;
         else    return (c == 0) ? maxv(i) : c - 1;
      end
      return c;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s[u%0d] actual=%0d required=%0d at %0t", nm, i, act, req, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < N; i++) begin
         chk({tag, "_cnt_err"}, i, int'(ce_o[i]), 0);
         chk({tag, "_t_err"},   i, int'(te_o[i]), 0);
         chk({tag, "_fail"},    i, int'(fl_o[i]), 0);
         chk({tag, "_err_cnt"}, i, ec_of(i), 0);
         chk({tag, "_chk_cnt"}, i, cc_of(i), 0);
         chk({tag, "_state"},   i, int'(st_o[i]), 0);
      end
   endtask

   // Behavioural reference: what each monitor must report after this edge.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < N; i++) begin
         m_ce[i] = 1'b0;
         m_te[i] = 1'b0;
         if (rst || clr) begin
            m_st[i] = 0; m_exp[i] = 0; m_ec[i] = 0; m_cc[i] = 0; m_fail[i] = 1'b0;
         end else begin
            mb = int'(cnt_s[i]);
            if (m_st[i] == 1) begin
               mce = (int'(cnt_s[i]) != m_exp[i]) || (int'(cnt_s[i]) > maxv(i));
               mte = t_s[i] != (up_s[i] ? (int'(cnt_s[i]) == maxv(i)) : (cnt_s[i] == 4'd0));
               m_ce[i] = mce;
               m_te[i] = mte;
               if (m_cc[i] < errmax(i)) m_cc[i]++;
               if (mce || mte) begin
                  m_fail[i] = 1'b1;
                  if (m_ec[i] < errmax(i)) m_ec[i]++;
                  if (stop(i)) m_st[i] = 2;
               end
               if (!mce) mb = m_exp[i];
            end else if (m_st[i] == 0) begin
               m_st[i] = 1;
            end
            m_exp[i] = cnext(i, mb, en_s[i], up_s[i], ld_s[i], lv_s[i]);
         end
      end
   end

   // Compare every monitor output against the model, away from the edge.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         chk("cnt_err", i, int'(ce_o[i]), int'(m_ce[i]));
         chk("t_err",   i, int'(te_o[i]), int'(m_te[i]));
         chk("fail",    i, int'(fl_o[i]), int'(m_fail[i]));
         chk("err_cnt", i, ec_of(i), m_ec[i]);
         chk("chk_cnt", i, cc_of(i), m_cc[i]);
         chk("state",   i, int'(st_o[i]), m_st[i]);
      end
   end

   // Advance past the next edge: the counters take their sampled controls.
   task automatic edge_adv();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         ctr[i]   = cnext(i, ctr[i], en_s[i], up_s[i], ld_s[i], lv_s[i]);
         tflip[i] = 1'b0;
      end
   endtask

   // Drive the counter outputs (count and terminal flag, optionally faulted).
   task automatic present();
      for (int i = 0; i < N; i++) begin
         cnt_s[i] = 4'(ctr[i]);
         t_s[i]   = (up_s[i] ? (ctr[i] == maxv(i)) : (ctr[i] == 0)) ^ tflip[i];
      end
   endtask

   task automatic set_ctl(input int i, input logic en, input logic up,
                          input logic ld, input int lv);
      en_s[i] = en; up_s[i] = up; ld_s[i] = ld; lv_s[i] = 4'(lv);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         set_ctl(i, 1'b0, 1'b1, 1'b0, 0);
         ctr[i]   = 0;
         tflip[i] = 1'b0;
      end
      present();
      repeat (2) @(posedge clk);
      #3;
      chk_zero("reset");

      // Full-range up count on u0; the others hold.
      @(posedge clk);
      #2;
      rst = 1'b0;
      set_ctl(0, 1'b1, 1'b1, 1'b0, 0);
      present();
      repeat (20) begin
         edge_adv();
         present();
      end
      chk("upcount_chk_cnt", 0, int'(cc0), 19);
      chk("upcount_err_cnt", 0, int'(ec0), 0);

      // Load 3 then count down on u1 (MAX=9): 3,2,1,0,9,8,...
      set_ctl(1, 1'b0, 1'b0, 1'b1, 3);
      present();
      edge_adv();
      set_ctl(1, 1'b1, 1'b0, 1'b0, 0);
      present();
      repeat (8) begin
         edge_adv();
         present();
      end
      chk("down_err_cnt", 1, int'(ec1), 0);
      chk("down_fail", 1, int'(fl_o[1]), 0);

      // u0 counter skips 5 -> 7; 8 must then be accepted.
      for (int k = 0; k < 20; k++) begin
         edge_adv();
         if (ctr[0] == 6) begin
            ctr[0] = 7;
            present();
            break;
         end
         present();
      end
      edge_adv();
      present();
      #1;
      chk("skip_cnt_err", 0, int'(ce_o[0]), 1);
      edge_adv();
      present();
      #1;
      chk("skip_resync", 0, int'(ce_o[0]), 0);
      chk("skip_err_cnt", 0, int'(ec0), 1);
      chk("skip_fail", 0, int'(fl_o[0]), 1);

      // u0 terminal flag held low at count 15 while counting up.
      for (int k = 0; k < 20; k++) begin
         edge_adv();
         if (ctr[0] == 15) begin
            tflip[0] = 1'b1;
            present();
            break;
         end
         present();
      end
      edge_adv();
      present();
      #1;
      chk("tfault_t_err", 0, int'(te_o[0]), 1);
      chk("tfault_err_cnt", 0, int'(ec0), 2);

      // u1 (MAX=9) shows an out-of-range 12.
      edge_adv();
      ctr[1] = 12;
      present();
      edge_adv();
      present();
      #1;
      chk("range_cnt_err", 1, int'(ce_o[1]), 1);
      chk("range_err_cnt", 1, int'(ec1), 1);

      // Ten faults into u1 (saturating tally) and u2 (halts on first).
      for (int k = 0; k < 10; k++) begin
         edge_adv();
         ctr[1] = (ctr[1] + 3) % 10;
         ctr[2] = (ctr[2] + 3) % 16;
         present();
         edge_adv();
         present();
         if (k == 0) begin
            #1;
            chk("halt_first_state", 2, int'(st_o[2]), 2);
            chk("halt_first_err_cnt", 2, int'(ec2), 1);
         end
      end
      #1;
      chk("halt_state", 2, int'(st_o[2]), 2);
      chk("halt_err_cnt", 2, int'(ec2), 1);
      chk("sat_err_cnt", 1, int'(ec1), 7);

      // clr pulse: back to SYNC with tallies cleared.
      clr = 1'b1;
      present();
      edge_adv();
      clr = 1'b0;
      present();
      #1;
      chk_zero("clr");

      // Randomized traffic with occasional faults and clears.
      for (int k = 0; k < 400; k++) begin
         edge_adv();
         clr = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < N; i++) begin
            set_ctl(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, maxv(i))));
            if ($urandom_range(0, 15) == 0) ctr[i] = int'($urandom_range(0, 15));
            tflip[i] = ($urandom_range(0, 15) == 0);
         end
         present();
      end
      clr = 1'b0;
      for (int i = 0; i < N; i++) set_ctl(i, 1'b1, 1'b1, 1'b0, 0);
      repeat (5) begin
         edge_adv();
         present();
      end

      // Asynchronous reset mid-count clears outputs without an edge.
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (10) begin
         edge_adv();
         present();
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
